mdu_div: RTL

Parametrised iterative restoring divider for the execute stage, the multi-cycle successor to the two-cycle multiply-accumulate path. Accepts a signed or unsigned WIDTH-bit divide, runs one quotient bit per clock, and returns {remainder, quotient} for the HI/LO write. The execute stage holds its stall request while `start_i` is high and `ready_o` is low. An annul input lets the pipeline cancel an in-flight divide on flush.

---
 rtl/mdu_div.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mdu_div.sv
// mdu_div: iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Optional MDU_DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 by_zero_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, quo;
    logic             neg_q, neg_r, byz;
    logic [WIDTH-1:0] mag1, mag2, rem_nx, quo_nx;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;

    assign busy_o = (state != FREE);

    // Operand magnitudes and one restoring trial-subtract step; the extra top bit of diff is the borrow.
    always_comb begin
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted = {rem, dvd[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs};
        ge      = !diff[WIDTH+1];
        rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ge};
    end

    // Control FSM and datapath; results are staged in rem/quo and published on the END cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FREE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            byz       <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            by_zero_o <= 1'b0;
        end else if (annul_i) begin
            state     <= FREE;
            result_o  <= '0;
            ready_o   <= 1'b0;
            by_zero_o <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i) begin
                        cnt   <= '0;
                        neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                        byz   <= 1'b0;
                        dvd   <= mag1;
                        dvs   <= mag2;
                        rem   <= '0;
                        quo   <= '0;
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
`ifdef MDU_DIV_EARLY_EXIT_EN
                        end else if (mag1 < mag2) begin
                            state <= END;
                            rem   <= opdata1_i;
`endif
                        end else begin
                            state <= ON;
                        end
                    end
                end
                BYZERO: begin
                    state <= END;
                    rem   <= '0;
                    quo   <= '0;
                    byz   <= 1'b1;
                end
                ON: begin
                    dvd <= dvd << 1;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= END;
                        quo   <= neg_q ? -quo_nx : quo_nx;
                        rem   <= neg_r ? -rem_nx : rem_nx;
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_o   <= 1'b1;
                        result_o  <= {rem, quo};
                        by_zero_o <= byz;
                    end else begin
                        state     <= FREE;
                        ready_o   <= 1'b0;
                        result_o  <= '0;
                        by_zero_o <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
